seq_alu_engine: RTL and testbench

- Parametrised successor to the byte-stream adder in the UART ALU datapath.
- Collects N little-endian operands from the UART RX byte stream and left-folds them with the selected operation (ADD, MUL, DIV).
- Reports the result and an error flag to the UART control state machine.
- Replaces separate add/mul/div instances with one engine using a shared iterative multiply/divide unit.

---
 rtl/seq_alu_pkg.sv | 23 ++
 rtl/seq_muldiv.sv | 79 +++++++
 rtl/seq_alu_engine.sv | 159 +++++++++++++++
 tb/tb_seq_alu_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU engine: operation codes, FSM states
// and the operand byte-count helper.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_MUL  = 2'd1,
        OP_DIV  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EXEC,
        FINISH
    } state_e;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply / restoring divide sharing one shift register
// set and one adder; q is valid while done pulses, width_p iterations after start.
module seq_muldiv
    import seq_alu_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  op_e                op,
    input  logic [width_p-1:0] a,
    input  logic [width_p-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [width_p-1:0] q
);

    localparam int CW = $clog2(width_p + 1);

    // acc: product (MUL) or partial remainder (DIV)
    // sh:  multiplier shifting right (MUL) or dividend -> quotient (DIV)
    // m:   multiplicand shifting left (MUL) or divisor (DIV)
    logic [width_p-1:0] acc, sh, m;
    logic [CW-1:0]      cnt;
    logic               is_mul, done_r;
    logic [width_p:0]   add_a, add_b;
    logic               cin;
    logic [width_p+1:0] sum;

    always_comb begin
        add_a = {1'b0, acc};
        add_b = {1'b0, (sh[0] ? m : {width_p{1'b0}})};
        cin   = 1'b0;
        if (!is_mul) begin
            // trial subtract: carry out set means shifted remainder >= divisor
            add_a = {acc, sh[width_p-1]};
            add_b = ~{1'b0, m};
            cin   = 1'b1;
        end
        sum = {1'b0, add_a} + {1'b0, add_b} + {{(width_p+1){1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            sh     <= '0;
            m      <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start && !busy) begin
                is_mul <= (op == OP_MUL);
                acc    <= '0;
                sh     <= (op == OP_MUL) ? b : a;
                m      <= (op == OP_MUL) ? a : b;
                cnt    <= CW'(width_p);
            end else if (busy) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) done_r <= 1'b1;
                if (is_mul) begin
                    acc <= sum[width_p-1:0];
                    sh  <= sh >> 1;
                    m   <= m << 1;
                end else begin
                    acc <= sum[width_p+1] ? sum[width_p-1:0] : add_a[width_p-1:0];
                    sh  <= {sh[width_p-2:0], sum[width_p+1]};
                end
            end
        end
    end

    assign busy = (cnt != '0);
    assign done = done_r;
    assign q    = is_mul ? acc : sh;

endmodule

// File: rtl/seq_alu_engine.sv
// Collects little-endian operands from a byte stream and left-folds them with
// ADD, MUL or DIV; reports the final accumulator and a sticky error flag.
module seq_alu_engine
    import seq_alu_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int len_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [len_width_p-1:0] len_i,
    input  logic [7:0]             data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   done_o,
    output logic [width_p-1:0]     result_o,
    output logic                   error_o
);

    localparam int BPW = bytes_per_word(width_p);
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [width_p-1:0]     acc_q, acc_d, word_q, word_d, res_q, res_d, word_n;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [BIW-1:0]         bidx_q, bidx_d;
    logic                   first_q, first_d, err_q, err_d, cerr_q, cerr_d;
    logic                   bad_cmd, last_byte, exec_done;
    logic                   md_start, md_busy, md_done;
    logic [width_p-1:0]     md_q;

    assign bad_cmd   = (len_i == '0) || ((len_i % len_width_p'(BPW)) != '0) || (op_i == 2'd3);
    assign last_byte = (bidx_q == BIW'(BPW - 1));

    always_comb begin
        word_n = word_q;
        for (int k = 0; k < BPW; k++)
            if (bidx_q == BIW'(k)) word_n[8*k +: 8] = data_i;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        word_d    = word_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        first_d   = first_q;
        err_d     = err_q;
        cerr_d    = cerr_q;
        md_start  = 1'b0;
        exec_done = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                op_d    = op_e'(op_i);
                cnt_d   = len_i;
                acc_d   = '0;
                bidx_d  = '0;
                first_d = 1'b1;
                err_d   = 1'b0;
                cerr_d  = 1'b0;
                state_d = COLLECT;
                // rejected commands pass through one empty EXEC cycle so done
                // lands two cycles after start
                if (bad_cmd) begin
                    err_d   = 1'b1;
                    cerr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            COLLECT: if (valid_i) begin
                word_d = word_n;
                cnt_d  = cnt_q - len_width_p'(1);
                bidx_d = bidx_q + BIW'(1);
                if (last_byte) begin
                    bidx_d = '0;
                    if (first_q) begin
                        acc_d   = word_n;
                        first_d = 1'b0;
                        if (cnt_q == len_width_p'(1)) state_d = FINISH;
                    end else begin
                        state_d  = EXEC;
                        md_start = !md_busy && (op_q != OP_ADD) &&
                                   !(op_q == OP_DIV && word_n == '0);
                    end
                end
            end
            EXEC: begin
                if (cerr_q) begin
                    exec_done = 1'b1;
                end else if (op_q == OP_ADD) begin
                    acc_d     = acc_q + word_q;
                    exec_done = 1'b1;
                end else if (op_q == OP_DIV && word_q == '0) begin
                    acc_d     = '1;
                    err_d     = 1'b1;
                    exec_done = 1'b1;
                end else if (md_done) begin
                    acc_d     = md_q;
                    exec_done = 1'b1;
                end
                if (exec_done) state_d = (cnt_q == '0) ? FINISH : COLLECT;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // result register loads on entry so it is valid alongside done_o
        if (state_d == FINISH && state_q != FINISH) res_d = acc_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            acc_q   <= '0;
            word_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            first_q <= first_d;
            err_q   <= err_d;
            cerr_q  <= cerr_d;
        end
    end

    seq_muldiv #(.width_p(width_p)) u_muldiv (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (md_start),
        .op    (op_q),
        .a     (acc_q),
        .b     (word_n),
        .busy  (md_busy),
        .done  (md_done),
        .q     (md_q)
    );

    assign ready_o  = (state_q == COLLECT);
    assign done_o   = (state_q == FINISH);
    assign result_o = res_q;
    assign error_o  = err_q;

endmodule

// File: tb/tb_seq_alu_engine.sv
// Table-driven bench for seq_alu_engine with a result scoreboard and
// hand-written reset / ignored-start sequences.
module tb_seq_alu_engine;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] len = 16'd0;
    logic [7:0]  data = 8'd0;
    logic        ready, done, error;
    logic [31:0] result;

    seq_alu_engine #(.width_p(32), .len_width_p(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .len_i    (len),
        .data_i   (data),
        .valid_i  (valid),
        .ready_o  (ready),
        .done_o   (done),
        .result_o (result),
        .error_o  (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [15:0]      len;
        int               nops;
        logic [2:0][31:0] opnd;
        bit               rnd;
        bit               poke;
        logic [31:0]      res;
        bit               err;
        int               lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        bit          err;
    } exp_t;

    exp_t sb[$];
    vec_t vt[14];
    int   n_vec = 0, n_bad = 0, cyc = 0;

    function automatic vec_t mk(input logic [1:0] o, input logic [15:0] l, input int n,
                                input logic [31:0] a0, a1, a2, input bit r, p,
                                input logic [31:0] res, input bit err, input int lat);
        vec_t v;
        v.op = o; v.len = l; v.nops = n;
        v.opnd[0] = a0; v.opnd[1] = a1; v.opnd[2] = a2;
        v.rnd = r; v.poke = p; v.res = res; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   last, guard;
        bit   acc, rdy_seen;
        exp_t e;
        op    = v.op;
        len   = v.len;
        start = 1'b1;
        e.res = v.res;
        e.err = v.err;
        sb.push_back(e);
        last  = cyc;
        tick();
        start = 1'b0;
        for (int b = 0; b < v.nops * 4; b++) begin
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 200) begin
                valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                data  = v.opnd[b/4][8*(b%4) +: 8];
                if (v.poke && b == 2 && guard == 0) begin
                    start = 1'b1; op = 2'd3; len = 16'd6;
                end
                acc = valid && ready;
                if (acc) last = cyc;
                guard++;
                tick();
                start = 1'b0;
            end
            if (!acc) begin
                n_vec++; n_bad++;
                $display("FAIL %s byte %0d: not accepted in 200 cycles, want accepted", tag, b);
                valid = 1'b0;
                return;
            end
        end
        valid    = 1'b0;
        guard    = 0;
        rdy_seen = 1'b0;
        while (!done && guard < 200) begin
            if (ready) rdy_seen = 1'b1;
            tick();
            guard++;
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL %s done: no done_o within 200 cycles, want done_o", tag);
            return;
        end
        check({tag, " latency"}, 32'(cyc - last), 32'(v.lat));
        if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s scoreboard: got empty queue, want an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " result"}, result, e.res);
            check({tag, " error"}, 32'(error), 32'(e.err));
        end
        check({tag, " ready in exec"}, 32'(rdy_seen), 32'd0);
        tick();
        check({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit seen;
        vt[0]  = mk(2'd0, 16'd12, 3, 32'h1, 32'hFFFFFFFF, 32'h5, 0, 0, 32'h5, 0, 2);
        vt[1]  = mk(2'd1, 16'd8, 2, 32'h00010001, 32'h00010001, 0, 0, 0, 32'h00020001, 0, 34);
        vt[2]  = mk(2'd2, 16'd12, 3, 32'd1000, 32'd7, 32'd3, 1, 0, 32'd47, 0, 34);
        vt[3]  = mk(2'd2, 16'd12, 3, 32'd100, 32'd0, 32'd5, 0, 0, 32'h33333333, 1, 34);
        vt[4]  = mk(2'd0, 16'd4, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1);
        vt[5]  = mk(2'd0, 16'd6, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2);
        vt[6]  = mk(2'd0, 16'd8, 2, 32'h12345678, 32'h11111111, 0, 1, 0, 32'h23456789, 0, 2);
        vt[7]  = mk(2'd3, 16'd4, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2);
        vt[8]  = mk(2'd1, 16'd12, 3, 32'd3, 32'd5, 32'd7, 0, 0, 32'd105, 0, 34);
        vt[9]  = mk(2'd0, 16'd8, 2, 32'd2, 32'd3, 0, 0, 1, 32'd5, 0, 2);
        vt[10] = mk(2'd0, 16'd0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2);
        vt[11] = mk(2'd1, 16'd8, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'h1, 0, 34);
        vt[12] = mk(2'd2, 16'd8, 2, 32'd7, 32'd9, 0, 0, 0, 32'h0, 0, 34);
        vt[13] = mk(2'd2, 16'd8, 2, 32'd5, 32'd0, 0, 0, 0, 32'hFFFFFFFF, 1, 2);

        repeat (3) tick();
        check("reset ready", 32'(ready), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset error", 32'(error), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // abort an ADD after 5 of 8 bytes
        op = 2'd0; len = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            valid = 1'b1; data = 8'(b + 1);
            tick();
        end
        valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst ready", 32'(ready), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst error", 32'(error), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || ready) seen = 1'b1;
            tick();
        end
        check("midrst quiet", 32'(seen), 32'd0);
        run_vec(mk(2'd0, 16'd8, 2, 32'd2, 32'd3, 0, 0, 0, 32'd5, 0, 2), "post_reset_add");

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
